// File: rtl/demux_deser4.sv
// Serial-to-parallel demux: steers accepted bits LSB-first into WIDTH lanes; word valid on the edge capturing the last bit.
// Backpressure: in_ready drops while a word waits in HOLD; one bubble cycle per word on handoff.
module demux_deser4 #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] lane
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_lane;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_lane  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (flush) begin
                        r_lane <= '0;
                        r_data <= '0;
                    end else if (in_valid) begin
                        r_data[r_lane] <= in_bit;
                        if (r_lane == LAST_LANE) begin
                            r_lane  <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_lane <= r_lane + IDX_W'(1);
                        end
                    end
                end
                // Completed word is never discarded; only the consumer releases it.
                HOLD: begin
                    if (out_ready) begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_data;
    assign lane      = r_lane;

endmodule

// File: tb/tb_demux_deser4.sv
// Directed bench for demux_deser4: hand-computed words, gaps, flush, back-to-back, HOLD immunity, async reset.
module tb_demux_deser4;

    logic       clk;
    logic       rst_n;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] lane;

    int n_checks;
    int n_errors;

    demux_deser4 #(.WIDTH(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane      (lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) check("ready_valid_excl", {31'd0, in_ready & out_valid}, 32'd0);
    end

    logic [7:0] seq;
    int         k;
    int         bubbles;
    logic       acc;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_lane", {30'd0, lane}, 32'd0);
        check("rst_data", {28'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Word 1101, held 10 cycles
        send(1'b1);
        send(1'b0);
        check("t1_lane2", {30'd0, lane}, 32'd2);
        send(1'b1);
        check("t1_valid_early", {31'd0, out_valid}, 32'd0);
        send(1'b1);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data", {28'd0, out_data}, 32'h0000000d);
        check("t1_lane", {30'd0, lane}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t1_hold_valid", {31'd0, out_valid}, 32'd1);
        check("t1_hold_data", {28'd0, out_data}, 32'h0000000d);
        release_word();
        check("t1_rel_valid", {31'd0, out_valid}, 32'd0);
        check("t1_rel_ready", {31'd0, in_ready}, 32'd1);

        // Gapped word 0110
        seq = 8'b0000_0110;
        for (int i = 0; i < 4; i++) begin
            send(seq[i]);
            for (int g = 0; g < 3; g++) tick();
            if (i < 3) begin
                check("t2_lane", {30'd0, lane}, i + 1);
                check("t2_valid_early", {31'd0, out_valid}, 32'd0);
            end
        end
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_data", {28'd0, out_data}, 32'h00000006);
        release_word();

        // Flush after two bits, with a competing valid bit
        send(1'b1);
        send(1'b1);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t3_lane", {30'd0, lane}, 32'd0);
        check("t3_data", {28'd0, out_data}, 32'd0);
        check("t3_valid", {31'd0, out_valid}, 32'd0);
        send(1'b0);
        send(1'b0);
        send(1'b0);
        send(1'b1);
        check("t3_word_valid", {31'd0, out_valid}, 32'd1);
        check("t3_word_data", {28'd0, out_data}, 32'h00000008);
        release_word();

        // Back-to-back A then 5 with out_ready tied high
        seq       = 8'h5A;
        k         = 0;
        bubbles   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            acc    = in_ready;
            in_bit = seq[k % 8];
            if (!acc) bubbles++;
            tick();
            if (acc) k++;
            if (c == 3) begin
                check("t4_w1_valid", {31'd0, out_valid}, 32'd1);
                check("t4_w1_data", {28'd0, out_data}, 32'h0000000a);
            end
        end
        in_valid = 1'b0;
        check("t4_w2_valid", {31'd0, out_valid}, 32'd1);
        check("t4_w2_data", {28'd0, out_data}, 32'h00000005);
        check("t4_accepts", k, 32'd8);
        check("t4_bubbles", bubbles, 32'd1);
        tick();
        out_ready = 1'b0;
        check("t4_back_fill", {31'd0, in_ready}, 32'd1);

        // HOLD ignores in_valid and flush
        send(1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b0);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_data", {28'd0, out_data}, 32'h00000003);
            check("t5_lane", {30'd0, lane}, 32'd0);
            check("t5_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        release_word();

        // Asynchronous reset mid-word
        send(1'b1);
        send(1'b1);
        send(1'b1);
        check("t6_lane_pre", {30'd0, lane}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_data", {28'd0, out_data}, 32'd0);
        check("t6_lane", {30'd0, lane}, 32'd0);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        #1;
        rst_n = 1'b1;
        send(1'b1);
        send(1'b0);
        send(1'b0);
        send(1'b1);
        check("t6_word_valid", {31'd0, out_valid}, 32'd1);
        check("t6_word_data", {28'd0, out_data}, 32'h00000009);
        release_word();
        check("t6_rel_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
